serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_fa1.sv | 13 +
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared state encoding and default width for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int SERIAL_ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa1.sv
// Combinational 1-bit full adder cell driven once per cycle by the sequencer.
module fa1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: latches operands on start, adds LSB first through fa1.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
//
// state  | meaning
// S_IDLE | waiting for start; last result held
// S_RUN  | one operand bit per cycle through the full adder
// S_DONE | one-cycle done pulse; start re-accepted here
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  state_t state, state_nxt;
  logic accept;
  logic last;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_nxt;

  fa1 u_fa1 (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign sum_nxt = {fa_s, sum_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result registers only load on the final RUN bit so sum/cout hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= cin;
    end else if (state == S_RUN) begin
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      sum_sh <= sum_nxt[WIDTH-1:1];
      carry  <= fa_co;
      if (last) begin
        sum  <= sum_nxt;
        cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
        ovf  <= carry ^ fa_co;
`endif
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge following the accepting posedge.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cnt, output int lat, output logic ok);
    busy_cnt = 0; lat = 1; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int bc, lat, dcnt, n;
    logic ok;
    logic [7:0] rsum;
    logic rcout;
    int d_idx[2];
    logic [7:0] d_sum[2];
    logic d_cout[2];

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf",  ovf,  0);
`endif
    rst_n = 1'b1;

    // 0x5A + 0x3C
    start_op(8'h5A, 8'h3C, 1'b0);
    chk("t1_busy_start", busy, 1);
    wait_done(bc, lat, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_latency", lat, 9);
    chk("t1_busy_cycles", bc, 8);
    chk("t1_busy_in_done", busy, 0);
    chk("t1_sum", sum, 8'h96);
    chk("t1_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("t1_ovf", ovf, 1);
`endif
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // 0xFF + 0x01
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(bc, lat, ok);
    chk("t2_done_seen", ok, 1);
    chk("t2_busy_cycles", bc, 8);
    chk("t2_sum", sum, 8'h00);
    chk("t2_cout", cout, 1);
`ifdef SERIAL_ADD_OVF_EN
    chk("t2_ovf", ovf, 0);
`endif

    // 0x80 + 0x80 + 1, then hold through idle
    start_op(8'h80, 8'h80, 1'b1);
    wait_done(bc, lat, ok);
    chk("t3_done_seen", ok, 1);
    chk("t3_sum", sum, 8'h01);
    chk("t3_cout", cout, 1);
`ifdef SERIAL_ADD_OVF_EN
    chk("t3_ovf", ovf, 1);
`endif
    a = 8'hAA; b = 8'h55; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_sum", sum, 8'h01);
      chk("t3_hold_idle", {busy, done}, 2'b00);
    end

    // start during RUN is ignored
    start_op(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; rsum = '0; rcout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dcnt++;
        rsum = sum;
        rcout = cout;
      end
      @(negedge clk);
    end
    chk("t4_done_count", dcnt, 1);
    chk("t4_sum", rsum, 8'h30);
    chk("t4_cout", rcout, 0);

    // async reset at RUN bit 4
    start_op(8'h5A, 8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    chk("t5_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_sum", sum, 0);
    chk("t5_rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) dcnt++;
      @(negedge clk);
    end
    chk("t5_no_done_after_rst", dcnt, 0);
    start_op(8'h01, 8'h02, 1'b0);
    wait_done(bc, lat, ok);
    chk("t5_done_seen", ok, 1);
    chk("t5_sum", sum, 8'h03);
    chk("t5_cout", cout, 0);

    // back-to-back with start held high
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 8'h0F; b = 8'h01;
    n = 0;
    d_idx[0] = 0; d_idx[1] = 0;
    d_sum[0] = '0; d_sum[1] = '0;
    d_cout[0] = 1'b1; d_cout[1] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        if (n < 2) begin
          d_idx[n] = i;
          d_sum[n] = sum;
          d_cout[n] = cout;
        end
        n++;
        chk("t6_busy_in_done", busy, 0);
      end
      if (n >= 1 && !done) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("t6_done_count", n, 2);
    chk("t6_spacing", d_idx[1] - d_idx[0], 9);
    chk("t6_sum0", d_sum[0], 8'h33);
    chk("t6_sum1", d_sum[1], 8'h10);
    chk("t6_cout1", d_cout[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
